// File: rtl/mod_n_digit_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod_n_digit_stage_pkg                                        |
// | Description : Shared types and helpers for the two-digit modulo stage.     |
// |               Holds the tracking state type, the count direction           |
// |               constants and the modulo step function shared by the         |
// |               units and tens digit counters.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mod_n_digit_stage_pkg;

  // SYNC re-captures the upstream count; TRACK follows it one unit at a time.
  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // One modulo step of a 4-bit digit whose range is 0..modulus-1.
  // modulus is 5 bits wide so that a full 16-value digit can be described.
  function automatic logic [3:0] mod_step(input logic [3:0] val,
                                          input logic [4:0] modulus,
                                          input logic       dir);
    logic [4:0] top_wide;
    logic [3:0] top;
    top_wide = modulus - 5'd1;
    top      = top_wide[3:0];
    if (dir == DIR_UP) begin
      mod_step = (val == top) ? 4'd0 : val + 4'd1;
    end else begin
      mod_step = (val == 4'd0) ? top : val - 4'd1;
    end
  endfunction

endpackage : mod_n_digit_stage_pkg
`default_nettype wire

// File: rtl/mod_n_digit_stage_mod_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod_digit                                                    |
// | Description : Single modulo-MODULUS digit counter. Increments or           |
// |               decrements by one per request, wraps at the range ends and   |
// |               raises a registered one-cycle pulse on each wrap. With SAT   |
// |               set the value sticks at the range ends instead of wrapping   |
// |               (the wrap pulse is still raised).                            |
// | Ports       : clk      - rising-edge clock                                 |
// |               rst_n    - asynchronous active-low reset                     |
// |               inc/dec  - step requests (inc wins if both are high)         |
// |               clr      - synchronous clear of value and pulses             |
// |               value    - current digit, 0..MODULUS-1                       |
// |               wrap_up  - pulse: value wrapped MODULUS-1 -> 0               |
// |               wrap_dn  - pulse: value wrapped 0 -> MODULUS-1               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mod_digit
  import mod_n_digit_stage_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter bit SAT     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] value,
  output logic       wrap_up,
  output logic       wrap_dn
);

  localparam logic [4:0] C_MOD = 5'(MODULUS);
  localparam logic [3:0] C_MAX = 4'(MODULUS - 1);

  logic [3:0] r_value;
  logic       r_wrap_up;
  logic       r_wrap_dn;
  logic [3:0] w_next;
  logic       w_wrap_up;
  logic       w_wrap_dn;

  always_comb begin
    w_next    = r_value;
    w_wrap_up = 1'b0;
    w_wrap_dn = 1'b0;
    if (inc) begin
      w_wrap_up = (r_value == C_MAX);
      w_next    = (SAT && w_wrap_up) ? r_value : mod_step(r_value, C_MOD, DIR_UP);
    end else if (dec) begin
      w_wrap_dn = (r_value == 4'd0);
      w_next    = (SAT && w_wrap_dn) ? r_value : mod_step(r_value, C_MOD, DIR_DOWN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value   <= 4'd0;
      r_wrap_up <= 1'b0;
      r_wrap_dn <= 1'b0;
    end else if (clr) begin
      r_value   <= 4'd0;
      r_wrap_up <= 1'b0;
      r_wrap_dn <= 1'b0;
    end else begin
      r_value   <= w_next;
      r_wrap_up <= w_wrap_up;
      r_wrap_dn <= w_wrap_dn;
    end
  end

  assign value   = r_value;
  assign wrap_up = r_wrap_up;
  assign wrap_dn = r_wrap_dn;

endmodule : mod_digit
`default_nettype wire

// File: rtl/mod_n_digit_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mod_n_digit_stage                                            |
// | Description : Follows the raw count of an upstream up/down counter and     |
// |               folds every unit step into a units digit (modulo MOD) that   |
// |               cascades into a tens digit (modulo TENS_MOD). Raises         |
// |               carry/borrow pulses on units wraps and a sticky jump_err     |
// |               on any count change that is not a unit step in the           |
// |               direction given by mode.                                     |
// | Ports       : clk      - rising-edge clock (shared with upstream counter)  |
// |               reset    - asynchronous active-low reset                     |
// |               cnt_in   - upstream raw count                                |
// |               mode     - upstream direction, 0 = up, 1 = down              |
// |               clr      - synchronous clear (upstream counter reset)        |
// |               digit    - units digit                                       |
// |               tens     - tens digit                                        |
// |               carry    - pulse on units wrap MOD-1 -> 0                    |
// |               borrow   - pulse on units wrap 0 -> MOD-1                    |
// |               jump_err - sticky non-unit / wrong-direction step flag       |
// | Options     : TENS_SAT_EN - when defined, tens saturates at 0 and          |
// |               TENS_MOD-1 instead of wrapping.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mod_n_digit_stage
  import mod_n_digit_stage_pkg::*;
#(
  parameter int CW       = 4,
  parameter int MOD      = 5,
  parameter int TENS_MOD = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] cnt_in,
  input  logic          mode,
  input  logic          clr,
  output logic [3:0]    digit,
  output logic [3:0]    tens,
  output logic          carry,
  output logic          borrow,
  output logic          jump_err
);

`ifdef TENS_SAT_EN
  localparam bit C_TENS_SAT = 1'b1;
`else
  localparam bit C_TENS_SAT = 1'b0;
`endif

  localparam logic [3:0] C_UNITS_MAX = 4'(MOD - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_prev;
  logic [CW-1:0] w_delta;
  logic          r_jump_err;
  logic          w_up_step;
  logic          w_dn_step;
  logic          w_bad_step;
  logic          w_tens_inc;
  logic          w_tens_dec;
  logic          w_tens_wrap_up;
  logic          w_tens_wrap_dn;
  logic          w_unused_tens_wrap;

  // Modular difference makes the upstream 15->0 and 0->15 wraps unit steps.
  assign w_delta = cnt_in - r_prev;

  always_comb begin
    w_state_next = r_state;
    w_up_step    = 1'b0;
    w_dn_step    = 1'b0;
    w_bad_step   = 1'b0;
    case (r_state)
      SYNC: begin
        w_state_next = TRACK;
      end
      TRACK: begin
        if (w_delta == '0) begin
          w_state_next = TRACK;
        end else if ((w_delta == CW'(1)) && (mode == DIR_UP)) begin
          w_up_step = 1'b1;
        end else if ((w_delta == {CW{1'b1}}) && (mode == DIR_DOWN)) begin
          w_dn_step = 1'b1;
        end else begin
          w_bad_step   = 1'b1;
          w_state_next = SYNC;
        end
      end
      default: begin
        w_state_next = SYNC;
      end
    endcase
    // clr overrides any step decision made this cycle.
    if (clr) begin
      w_up_step    = 1'b0;
      w_dn_step    = 1'b0;
      w_bad_step   = 1'b0;
      w_state_next = SYNC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // prev follows cnt_in every cycle: SYNC captures it, TRACK compares against it.
  // jump_err survives clr and only reset drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev     <= '0;
      r_jump_err <= 1'b0;
    end else begin
      r_prev <= cnt_in;
      if (w_bad_step) begin
        r_jump_err <= 1'b1;
      end
    end
  end

  // Tens moves on the same edge on which units wraps.
  assign w_tens_inc = w_up_step && (digit == C_UNITS_MAX);
  assign w_tens_dec = w_dn_step && (digit == 4'd0);

  mod_digit #(
    .MODULUS (MOD),
    .SAT     (1'b0)
  ) u_units (
    .clk     (clk),
    .rst_n   (reset),
    .inc     (w_up_step),
    .dec     (w_dn_step),
    .clr     (clr),
    .value   (digit),
    .wrap_up (carry),
    .wrap_dn (borrow)
  );

  mod_digit #(
    .MODULUS (TENS_MOD),
    .SAT     (C_TENS_SAT)
  ) u_tens (
    .clk     (clk),
    .rst_n   (reset),
    .inc     (w_tens_inc),
    .dec     (w_tens_dec),
    .clr     (clr),
    .value   (tens),
    .wrap_up (w_tens_wrap_up),
    .wrap_dn (w_tens_wrap_dn)
  );

  // Tens wrap pulses have no consumer at this level.
  assign w_unused_tens_wrap = w_tens_wrap_up | w_tens_wrap_dn;

  assign jump_err = r_jump_err;

endmodule : mod_n_digit_stage
`default_nettype wire

// File: tb/tb_mod_n_digit_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mod_n_digit_stage                                         |
// | Description : Directed bench for mod_n_digit_stage (CW=4, MOD=5,           |
// |               TENS_MOD=10). A reference model computes the expected        |
// |               outputs when each step is driven; they are queued and        |
// |               compared after the clock edge that should produce them.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mod_n_digit_stage;

  localparam int M_MOD  = 5;
  localparam int M_TENS = 10;

  logic       clk;
  logic       reset;
  logic [3:0] cnt_in;
  logic       mode;
  logic       clr;
  logic [3:0] digit;
  logic [3:0] tens;
  logic       carry;
  logic       borrow;
  logic       jump_err;

  typedef struct {
    logic [3:0] digit;
    logic [3:0] tens;
    logic       carry;
    logic       borrow;
    logic       jerr;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_track;
  int m_prev;
  int m_digit;
  int m_tens;
  int m_jerr;

  mod_n_digit_stage #(
    .CW       (4),
    .MOD      (M_MOD),
    .TENS_MOD (M_TENS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_in   (cnt_in),
    .mode     (mode),
    .clr      (clr),
    .digit    (digit),
    .tens     (tens),
    .carry    (carry),
    .borrow   (borrow),
    .jump_err (jump_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_track = 0;
    m_prev  = 0;
    m_digit = 0;
    m_tens  = 0;
    m_jerr  = 0;
  endtask

  task automatic tens_up();
`ifdef TENS_SAT_EN
    if (m_tens != M_TENS - 1) m_tens = m_tens + 1;
`else
    m_tens = (m_tens + 1) % M_TENS;
`endif
  endtask

  task automatic tens_dn();
`ifdef TENS_SAT_EN
    if (m_tens != 0) m_tens = m_tens - 1;
`else
    m_tens = (m_tens == 0) ? M_TENS - 1 : m_tens - 1;
`endif
  endtask

  // Drive one cycle of stimulus, push the model's expectation, then compare
  // after the edge that consumes it.
  task automatic step(input int c, input logic md, input logic cl, input string tag);
    exp_t e;
    int   d;
    cnt_in = 4'(c);
    mode   = md;
    clr    = cl;
    e.carry  = 1'b0;
    e.borrow = 1'b0;
    if (cl) begin
      m_digit = 0;
      m_tens  = 0;
      m_track = 0;
    end else if (m_track == 0) begin
      m_track = 1;
    end else begin
      d = (c - m_prev) & 15;
      if (d == 0) begin
      end else if (d == 1 && md == 1'b0) begin
        if (m_digit == M_MOD - 1) begin
          m_digit = 0;
          e.carry = 1'b1;
          tens_up();
        end else begin
          m_digit = m_digit + 1;
        end
      end else if (d == 15 && md == 1'b1) begin
        if (m_digit == 0) begin
          m_digit  = M_MOD - 1;
          e.borrow = 1'b1;
          tens_dn();
        end else begin
          m_digit = m_digit - 1;
        end
      end else begin
        m_jerr  = 1;
        m_track = 0;
      end
    end
    m_prev = c & 15;
    e.digit = 4'(m_digit);
    e.tens  = 4'(m_tens);
    e.jerr  = (m_jerr != 0);
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".digit"},  digit,           e.digit);
    chk({tag, ".tens"},   tens,            e.tens);
    chk({tag, ".carry"},  {3'b0, carry},   {3'b0, e.carry});
    chk({tag, ".borrow"}, {3'b0, borrow},  {3'b0, e.borrow});
    chk({tag, ".jerr"},   {3'b0, jump_err}, {3'b0, e.jerr});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".digit"},  digit,            4'd0);
    chk({tag, ".tens"},   tens,             4'd0);
    chk({tag, ".carry"},  {3'b0, carry},    4'd0);
    chk({tag, ".borrow"}, {3'b0, borrow},   4'd0);
    chk({tag, ".jerr"},   {3'b0, jump_err}, 4'd0);
  endtask

  initial begin
    reset  = 1'b0;
    cnt_in = 4'd0;
    mode   = 1'b0;
    clr    = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // SYNC capture, then up-count 1..7: carry on 4->5, tens reaches 1
    step(0, 1'b0, 1'b0, "sync0");
    for (int i = 1; i <= 7; i++) step(i, 1'b0, 1'b0, "up");

    // down-count 7->6->5
    step(6, 1'b1, 1'b0, "dn6");
    step(5, 1'b1, 1'b0, "dn5");
    // mode change without count change
    step(5, 1'b0, 1'b0, "mode_only");

    // up to 15, then upstream wrap 15->0 is a legal step
    for (int i = 6; i <= 15; i++) step(i, 1'b0, 1'b0, "up_hi");
    step(0, 1'b0, 1'b0, "wrap15_0");
    // down wrap 0->15 also legal
    step(15, 1'b1, 1'b0, "wrap0_15");
    step(0, 1'b0, 1'b0, "back0");

    // jump 3->6: error, then 6->7 ignored (SYNC), 7->8 counts
    for (int i = 1; i <= 3; i++) step(i, 1'b0, 1'b0, "pre_jump");
    step(6, 1'b0, 1'b0, "jump");
    step(7, 1'b0, 1'b0, "resync");
    step(8, 1'b0, 1'b0, "after_jump");

    // clr mid-count: digit/tens cleared, jump_err kept
    for (int i = 9; i <= 15; i++) step(i, 1'b0, 1'b0, "pre_clr");
    step(15, 1'b0, 1'b1, "clr");
    step(3, 1'b0, 1'b0, "post_clr_sync");
    step(4, 1'b0, 1'b0, "post_clr_up");

    // asynchronous reset in the middle of a cycle
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;

    // wrong-direction unit step flags an error
    step(0, 1'b0, 1'b0, "wd_sync");
    step(1, 1'b1, 1'b0, "wrong_dir");

    // fresh reset, then long up-count through tens TENS_MOD-1 -> wrap/saturate
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 1'b0, 1'b0, "long_sync");
    for (int i = 1; i <= 52; i++) step(i & 15, 1'b0, 1'b0, "long_up");
    // and back down across tens 0
    for (int i = 52; i >= 0; i--) step((i - 1) & 15, 1'b1, 1'b0, "long_dn");

    chk("sb_empty", 4'(sb.size()), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mod_n_digit_stage
`default_nettype wire

// File: doc/mod_n_digit_stage.md
Name: mod_n_digit_stage

Overview:
- Sits directly downstream of the 4-bit up/down counter and samples its raw count every clock.
- Folds each unit step into a modulo-MOD "units" digit and a modulo-TENS_MOD "tens" digit.
- Emits one-cycle carry/borrow pulses and flags any count jump that is not a unit step.
- Provides the cascaded two-digit value for display and terminal-count logic.

Parameters:
- CW, 4, width of the upstream count input
- MOD, 5, units-digit modulus (digit range 0..MOD-1), 2..16
- TENS_MOD, 10, tens-digit modulus (range 0..TENS_MOD-1), 2..16

Ports:
- clk  input  1  rising-edge clock, same clock as the upstream counter
- reset  input  1  asynchronous, active-low reset
- cnt_in  input  CW  raw count from the upstream counter
- mode  input  1  upstream direction: 0 = up, 1 = down
- clr  input  1  synchronous clear; driven by the upstream counter's (active-high) reset
- digit  output  4  units digit, 0..MOD-1
- tens  output  4  tens digit, 0..TENS_MOD-1
- carry  output  1  one-cycle pulse when digit wraps MOD-1 to 0
- borrow  output  1  one-cycle pulse when digit wraps 0 to MOD-1
- jump_err  output  1  sticky flag: non-unit or wrong-direction step seen

Behaviour:
- Reset (reset=0, asynchronous): state=SYNC; digit=0, tens=0, carry=0, borrow=0, jump_err=0; prev register=0.
- State SYNC:
  - captures cnt_in into prev; no digit change; next state TRACK.
  - Entered after reset and on every clr=1 cycle.
- State TRACK, each clock, with delta = (cnt_in - prev) mod 2^CW:
  - delta=0: hold.
  - delta=1 with mode=0: up step. digit==MOD-1 → digit=0, carry=1, tens+1 mod TENS_MOD; else digit+1.
  - delta=2^CW-1 with mode=1: down step. digit==0 → digit=MOD-1, borrow=1, tens-1 mod TENS_MOD; else digit-1.
  - any other delta, or a unit step against mode: jump_err=1, digit/tens hold, next state SYNC.
  - prev <= cnt_in every TRACK cycle.
- Upstream wrap 15→0 (up) and 0→15 (down) are legal unit steps via modular delta.
- clr=1 has priority over everything except reset:
  - digit=0, tens=0, carry=0, borrow=0, state=SYNC.
  - jump_err is NOT cleared by clr; it clears only on reset.
- carry/borrow are registered, high for exactly one cycle, and never both high.
- Latency: upstream count change at edge N is reflected on digit/tens/carry after edge N+1.
- Mode change with no count change: no effect.
- Mode change coincident with a step: the step is judged against the mode value sampled that same cycle.

Optional Feature:
- Macro: TENS_SAT_EN.
- Defined: tens saturates.
  - Carry at tens=TENS_MAX (TENS_MOD-1) holds tens at TENS_MAX.
  - Borrow at tens=0 holds tens at 0.
  - digit still wraps normally.
- Undefined: tens wraps modulo TENS_MOD as specified above.

Decomposition:
- Shared package holds:
  - state typedef (SYNC, TRACK)
  - direction constants DIR_UP=0, DIR_DOWN=1
  - a modular-increment/decrement function reused for digit and tens.
- One sub-module is natural: mod_digit (single modulo counter with inc/dec/clr inputs and wrap pulse outputs).
  - Instantiated twice: units (modulus MOD) and tens (modulus TENS_MOD, saturation per TENS_SAT_EN).

Test Plan:
- Reset, then cnt_in steps 0..7 with mode=0 (MOD=5) → digit 1,2,3,4,0,1,2; carry one pulse on step 4→5; tens=1.
- From digit=0, tens=1: cnt_in 7→6→5 with mode=1 → borrow pulse on first step; digit 4 then 3; tens 0.
- cnt_in 15→0 with mode=0 → legal step: digit increments, jump_err stays 0.
- cnt_in jumps 3→6 → jump_err=1, digit/tens hold; next step 6→7 ignored (SYNC); 7→8 counts.
- clr=1 mid-count with digit=3, tens=2 → digit=0, tens=0 next edge; jump_err unchanged; reset deasserted-to-asserted clears all asynchronously.
- TENS_SAT_EN defined, tens=9, carry → tens stays 9; undefined, same stimulus → tens=0.
